regfile_write_sched: RTL
========================

// Module: regfile_write_sched
// PURPOSE
//  Owns the single write port of the 2-read/1-write register file. Shares it
//  between two write requesters (req0 = ALU writeback, req1 = load/IO
//  writeback) using 2-way round-robin arbitration with a valid/ready handshake.
//  Zero-clears every register after reset and on demand (clear_req).
//  Sits between the writeback sources and regfile_base; read ports are untouched.
// PARAMETERS
//  SIZE   16  data width of one register entry
//  DEPTH  8   number of entries; AW = $clog2(DEPTH) is a derived localparam
// PORTS
//  clk         in   1     clock, all state on posedge
//  rst         in   1     reset, asynchronous, active-high
//  clear_req   in   1     pulse/level: request zero-clear of all entries
//  clear_busy  out  1     1 while FSM is in CLEAR
//  req0_valid  in   1     requester 0 has a write pending
//  req0_addr   in   AW    requester 0 target address
//  req0_data   in   SIZE  requester 0 write data
//  req0_ready  out  1     requester 0 write accepted this cycle (valid&ready)
//  req1_valid  in   1     requester 1 has a write pending
//  req1_addr   in   AW    requester 1 target address
//  req1_data   in   SIZE  requester 1 write data
//  req1_ready  out  1     requester 1 write accepted this cycle
//  wr_en       out  1     to regfile write_en (registered)
//  wr_addr     out  AW    to regfile waddr (registered)
//  wr_data     out  SIZE  to regfile write_data (registered)
//  wr_src      out  1     source of current wr_en beat: 0=req0, 1=req1
// BEHAVIOUR
//  Reset (async, rst=1): state=CLEAR, clr_cnt=0, prio=0; wr_en=0, wr_addr=0,
//   wr_data=0, wr_src=0; clear_busy=1 (decoded from state); both ready=0.
//  States: CLEAR, RUN. One write beat per cycle max.
//  CLEAR: each cycle register wr_en=1, wr_addr=clr_cnt, wr_data=0, wr_src=0;
//   clr_cnt++. When clr_cnt==DEPTH-1 (no power-of-2 assumption): clr_cnt<=0,
//   state<=RUN. CLEAR lasts exactly DEPTH cycles; last zero-write appears on
//   wr_* in the first RUN cycle. req*_ready=0 throughout; clear_req ignored.
//  RUN: readies are combinational from state, prio, valids, clear_req:
//   - clear_req=1 -> both ready=0, wr_en<=0, state<=CLEAR next edge.
//   - only one valid -> that requester ready=1.
//   - both valid -> requester == prio gets ready; prio<=other after grant.
//   - grant of a lone requester also sets prio<=other requester.
//   - no valid -> prio unchanged, wr_en<=0.
//   On grant: wr_en<=1, wr_addr/wr_data<=granted req, wr_src<=granted id.
//  Latency: accepted request -> wr_en on port next cycle -> in regfile the
//   edge after. No buffering: requester holds addr/data until ready.
//  Same-address requests in one cycle: only one granted; loser writes later,
//   so last-granted value wins. No read-after-write bypass (reader's job).
//  Valid with ready=0 must not change prio or any output.
//  rst mid-CLEAR or mid-RUN: in-flight beat dropped (wr_en=0 immediately),
//   clear restarts from address 0.
// STRUCTURE
//  Package regfile_pkg: state enum {CLEAR, RUN}; SRC_REQ0/SRC_REQ1 constants.
//  Sub-module rr_arbiter2: inputs valid[1:0], prio, block; outputs grant[1:0];
//   purely combinational; prio flop stays in regfile_write_sched.
//  Top: FSM + clr_cnt + output registers; instantiated beside regfile_base,
//   wr_* wired straight to its write port.
// TESTING (SIZE=16, DEPTH=8, bench includes regfile_base)
//  1 Release rst -> clear_busy=1 for 8 cycles, wr_addr 0..7 with wr_data=0,
//    then both ready=1 on valid; readback all entries = 0x0000.
//  2 RUN, req0 only: addr=3 data=0xBEEF -> req0_ready=1 same cycle; next cycle
//    wr_en=1 wr_addr=3 wr_data=0xBEEF wr_src=0; read_data0 at raddr0=3 =0xBEEF.
//  3 Both valid held 4 cycles, prio=0 -> grants 0,1,0,1; wr_src alternates.
//  4 Both valid, same addr=5: req0=0x1111 then req1=0x2222 -> entry5=0x2222.
//  5 clear_req with req0_valid=1 -> req0_ready=0, 8 clear beats, then req0
//    accepted; its write lands after all zero-writes.
//  6 Assert rst during CLEAR at clr_cnt=4 -> wr_en drops async; after release
//    clear restarts at addr 0 and runs full 8 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file write scheduler: FSM states and
// write-source identifiers carried on wr_src.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam logic SRC_REQ0 = 1'b0;
   localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational; the caller owns
// the priority flop and updates it from the grant vector.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       prio,
   input  logic       block,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (!block) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio == SRC_REQ1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/regfile_write_sched.sv
// Owns the register file write port: zero-clears every entry after reset or
// on clear_req, then shares the port between two writeback requesters.
module regfile_write_sched
   import regfile_pkg::*;
#(
   parameter  int SIZE  = 16,
   parameter  int DEPTH = 8,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear_req,
   output logic            clear_busy,
   input  logic            req0_valid,
   input  logic [AW-1:0]   req0_addr,
   input  logic [SIZE-1:0] req0_data,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [AW-1:0]   req1_addr,
   input  logic [SIZE-1:0] req1_data,
   output logic            req1_ready,
   output logic            wr_en,
   output logic [AW-1:0]   wr_addr,
   output logic [SIZE-1:0] wr_data,
   output logic            wr_src
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state;
   logic [AW-1:0] clr_cnt;
   logic          prio;
   logic [1:0]    grant;
   logic          block;

   // A pending clear takes the port away from both requesters this cycle.
   assign block = (state != RUN) || clear_req;

   rr_arbiter2 u_arb (
      .valid (({req1_valid, req0_valid})),
      .prio  (prio),
      .block (block),
      .grant (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign clear_busy = (state == CLEAR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         prio    <= SRC_REQ0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_src  <= SRC_REQ0;
      end else begin
         case (state)
            CLEAR: begin
               wr_en   <= 1'b1;
               wr_addr <= clr_cnt;
               wr_data <= '0;
               wr_src  <= SRC_REQ0;
               if (clr_cnt == LAST_ADDR) begin
                  clr_cnt <= '0;
                  state   <= RUN;
               end else begin
                  clr_cnt <= clr_cnt + AW'(1);
               end
            end
            RUN: begin
               if (clear_req) begin
                  wr_en <= 1'b0;
                  state <= CLEAR;
               end else if (grant[0]) begin
                  wr_en   <= 1'b1;
                  wr_addr <= req0_addr;
                  wr_data <= req0_data;
                  wr_src  <= SRC_REQ0;
                  prio    <= SRC_REQ1;
               end else if (grant[1]) begin
                  wr_en   <= 1'b1;
                  wr_addr <= req1_addr;
                  wr_data <= req1_data;
                  wr_src  <= SRC_REQ1;
                  prio    <= SRC_REQ0;
               end else begin
                  wr_en <= 1'b0;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
